// File: rtl/acq_playback_ctrl_if.sv
// rtl/acq_playback_ctrl_if.sv - sample memory bank link between bank and playback controller
interface acq_playback_ctrl_if #(
    parameter int SAMPLE_WIDTH = 3
);
    logic                    ready;
    logic                    sample_valid;
    logic                    frame_start;
    logic                    frame_end;
    logic [SAMPLE_WIDTH-1:0] data_in;
    logic                    mode;

    // Controller side: drives the bank mode, consumes its playback stream
    modport master (
        output mode,
        input  ready,
        input  sample_valid,
        input  frame_start,
        input  frame_end,
        input  data_in
    );

    // Bank side: follows mode, produces capture status and playback samples
    modport slave (
        input  mode,
        output ready,
        output sample_valid,
        output frame_start,
        output frame_end,
        output data_in
    );
endinterface

// File: rtl/acq_playback_ctrl.sv
// rtl/acq_playback_ctrl.sv - sequences sample bank capture/playback and accumulates per-bin frame sums
module acq_playback_ctrl #(
    parameter int SAMPLE_WIDTH = 3,
    parameter int FRAME_LEN    = 50400,
    parameter int NUM_BINS     = 16,
    parameter int BIN_WIDTH    = 6,
    parameter int SUM_WIDTH    = 20,
    parameter int MAG_WIDTH    = 19
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    acq_playback_ctrl_if.master         bank,
    output logic [BIN_WIDTH-1:0]        bin,
    output logic                        result_valid,
    output logic signed [SUM_WIDTH-1:0] sum_out,
    output logic [MAG_WIDTH-1:0]        mag_out,
    output logic                        busy,
    output logic                        done,
    output logic                        sync_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARM   = 3'd2,
        S_ACCUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [BIN_WIDTH-1:0] LAST_BIN = BIN_WIDTH'(NUM_BINS - 1);

    // Frame length is set by the bank's framing flags; a too-narrow magnitude sum only wraps
    if (7 * FRAME_LEN >= 2 ** MAG_WIDTH) begin : g_mag_sum_can_wrap
    end

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [SUM_WIDTH-1:0]   acc_sum_q, acc_sum_d;
    logic [MAG_WIDTH-1:0]   acc_mag_q, acc_mag_d;
    logic [SUM_WIDTH-1:0]   sum_out_q, sum_out_d;
    logic [MAG_WIDTH-1:0]   mag_out_q, mag_out_d;
    logic                   result_valid_q, result_valid_d;
    logic                   done_q, done_d;
    logic                   sync_error_q, sync_error_d;
    // Set after each frame_end: the next valid sample must open a new frame
    logic                   expect_start_q, expect_start_d;

    logic [SAMPLE_WIDTH-2:0] mag_code;
    logic [SUM_WIDTH-1:0]    smp_abs;
    logic [SUM_WIDTH-1:0]    smp_val;
    logic [MAG_WIDTH-1:0]    smp_mag;
    logic [SUM_WIDTH-1:0]    new_sum;
    logic [MAG_WIDTH-1:0]    new_mag;

    // Sign/magnitude decode: code m maps to 2m+1, negated when the sign bit is set
    always_comb begin
        mag_code = bank.data_in[SAMPLE_WIDTH-2:0];
        smp_abs  = SUM_WIDTH'({mag_code, 1'b1});
        smp_mag  = MAG_WIDTH'({mag_code, 1'b1});
        smp_val  = bank.data_in[SAMPLE_WIDTH-1] ? (~smp_abs + SUM_WIDTH'(1)) : smp_abs;
        // ARM seeds the sums with the frame's first sample; ACCUM adds to the running sums
        new_sum  = ((state_q == S_ARM) ? '0 : acc_sum_q) + smp_val;
        new_mag  = ((state_q == S_ARM) ? '0 : acc_mag_q) + smp_mag;
    end

    // Next-state and datapath control
    always_comb begin
        state_d        = state_q;
        bin_d          = bin_q;
        acc_sum_d      = acc_sum_q;
        acc_mag_d      = acc_mag_q;
        sum_out_d      = sum_out_q;
        mag_out_d      = mag_out_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        sync_error_d   = sync_error_q;
        expect_start_d = expect_start_q;

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d        = S_FILL;
                        sync_error_d   = 1'b0;
                        bin_d          = '0;
                        expect_start_d = 1'b0;
                    end
                end
                S_FILL: begin
                    if (bank.ready) begin
                        state_d = S_ARM;
                    end
                end
                S_ARM, S_ACCUM: begin
                    if (bank.sample_valid) begin
                        if (state_q == S_ARM && !bank.frame_start) begin
                            // Tail of a frame already in flight when playback began: skip it
                            state_d = S_ARM;
                        end else if (state_q == S_ACCUM && expect_start_q && !bank.frame_start) begin
                            // Lost framing: drop the sample and re-arm on the same bin
                            sync_error_d   = 1'b1;
                            acc_sum_d      = '0;
                            acc_mag_d      = '0;
                            expect_start_d = 1'b0;
                            state_d        = S_ARM;
                        end else if (bank.frame_end) begin
                            sum_out_d      = new_sum;
                            mag_out_d      = new_mag;
                            result_valid_d = 1'b1;
                            acc_sum_d      = '0;
                            acc_mag_d      = '0;
                            expect_start_d = 1'b1;
                            if (bin_q == LAST_BIN) begin
                                state_d = S_DONE;
                            end else begin
                                bin_d   = bin_q + BIN_WIDTH'(1);
                                state_d = S_ACCUM;
                            end
                        end else begin
                            acc_sum_d      = new_sum;
                            acc_mag_d      = new_mag;
                            expect_start_d = 1'b0;
                            state_d        = S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            bin_q          <= '0;
            acc_sum_q      <= '0;
            acc_mag_q      <= '0;
            sum_out_q      <= '0;
            mag_out_q      <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            sync_error_q   <= 1'b0;
            expect_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bin_q          <= bin_d;
            acc_sum_q      <= acc_sum_d;
            acc_mag_q      <= acc_mag_d;
            sum_out_q      <= sum_out_d;
            mag_out_q      <= mag_out_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            sync_error_q   <= sync_error_d;
            expect_start_q <= expect_start_d;
        end
    end

    // Bank is in playback only while waiting for or consuming frames
    always_comb begin
        bank.mode    = (state_q == S_ARM) || (state_q == S_ACCUM);
        busy         = (state_q != S_IDLE);
        bin          = bin_q;
        result_valid = result_valid_q;
        sum_out      = sum_out_q;
        mag_out      = mag_out_q;
        done         = done_q;
        sync_error   = sync_error_q;
    end

endmodule

// File: tb/tb_acq_playback_ctrl.sv
// tb/tb_acq_playback_ctrl.sv - self-checking bench for acq_playback_ctrl
module tb_acq_playback_ctrl;

    localparam int SW = 20;
    localparam int MW = 19;
    localparam int BW = 6;
    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 start;
    logic                 abort;
    logic [BW-1:0]        bin;
    logic                 result_valid;
    logic signed [SW-1:0] sum_out;
    logic [MW-1:0]        mag_out;
    logic                 busy;
    logic                 done;
    logic                 sync_error;

    acq_playback_ctrl_if #(.SAMPLE_WIDTH(3)) bank ();

    acq_playback_ctrl #(
        .SAMPLE_WIDTH(3),
        .FRAME_LEN   (16),
        .NUM_BINS    (NB),
        .BIN_WIDTH   (BW),
        .SUM_WIDTH   (SW),
        .MAG_WIDTH   (MW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .bank        (bank),
        .bin         (bin),
        .result_valid(result_valid),
        .sum_out     (sum_out),
        .mag_out     (mag_out),
        .busy        (busy),
        .done        (done),
        .sync_error  (sync_error)
    );

    typedef struct {
        int     sum;
        int     mag;
        longint due;
    } exp_t;

    exp_t        exp_q[$];
    longint      done_q[$];
    logic [2:0]  fr[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sval(input logic [2:0] s);
        int m;
        m = 2 * int'(s[1:0]) + 1;
        return s[2] ? -m : m;
    endfunction

    function automatic int smag(input logic [2:0] s);
        return 2 * int'(s[1:0]) + 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Every cycle: result_valid/done must occur exactly when the model schedules them
    always @(negedge clk) begin
        bit due_r;
        bit due_d;
        due_r = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("result_valid", longint'(result_valid), longint'(due_r));
        if (due_r) begin
            if (result_valid) begin
                chk("sum_out", longint'(sum_out), longint'(exp_q[0].sum));
                chk("mag_out", longint'(mag_out), longint'(exp_q[0].mag));
            end
            void'(exp_q.pop_front());
        end
        due_d = (done_q.size() > 0) && (done_q[0] == cyc);
        chk("done", longint'(done), longint'(due_d));
        if (due_d) void'(done_q.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit fs, input bit fe, input logic [2:0] d);
        tick();
        bank.sample_valid = v;
        bank.frame_start  = fs;
        bank.frame_end    = fe;
        bank.data_in      = d;
    endtask

    // Idle cycle with junk flags/data that must be ignored
    task automatic bubble();
        drive(1'b0, 1'b1, 1'b1, 3'b111);
    endtask

    task automatic pulse_start();
        tick();
        bank.sample_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Plays fr as one frame; counted frames schedule a result one cycle after frame_end
    task automatic play_frame(input bit counted, input bit last);
        int es;
        int em;
        es = 0;
        em = 0;
        foreach (fr[i]) begin
            es += sval(fr[i]);
            em += smag(fr[i]);
        end
        for (int i = 0; i < fr.size(); i++) begin
            if (i == 2) bubble();
            drive(1'b1, i == 0, i == fr.size() - 1, fr[i]);
        end
        if (counted) exp_q.push_back('{es, em, cyc + 1});
        if (last) done_q.push_back(cyc + 2);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mode"}, longint'(bank.mode), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_bin"}, longint'(bin), 0);
        chk({tag, "_sum"}, longint'(sum_out), 0);
        chk({tag, "_mag"}, longint'(mag_out), 0);
        chk({tag, "_sync_error"}, longint'(sync_error), 0);
    endtask

    initial begin
        reset_n           = 1'b0;
        start             = 1'b0;
        abort             = 1'b0;
        bank.ready        = 1'b0;
        bank.sample_valid = 1'b0;
        bank.frame_start  = 1'b0;
        bank.frame_end    = 1'b0;
        bank.data_in      = 3'b000;

        repeat (3) tick();
        @(negedge clk);
        check_reset_state("por");
        tick();
        reset_n = 1'b1;

        // Nominal run: constant +7 samples, two bins
        pulse_start();
        @(negedge clk);
        chk("fill_busy", longint'(busy), 1);
        chk("fill_mode", longint'(bank.mode), 0);
        pulse_start();
        @(negedge clk);
        chk("start_in_fill_busy", longint'(busy), 1);
        chk("start_in_fill_mode", longint'(bank.mode), 0);
        tick();
        bank.ready = 1'b1;
        tick();
        @(negedge clk);
        chk("arm_mode", longint'(bank.mode), 1);
        chk("arm_bin", longint'(bin), 0);
        fr.delete();
        repeat (16) fr.push_back(3'b011);
        play_frame(1'b1, 1'b0);
        bubble();
        @(negedge clk);
        chk("nom_bin1", longint'(bin), 1);
        chk("nom_sum_lit", longint'(sum_out), 112);
        chk("nom_mag_lit", longint'(mag_out), 112);
        play_frame(1'b1, 1'b1);
        repeat (3) bubble();
        @(negedge clk);
        chk("nom_end_mode", longint'(bank.mode), 0);
        chk("nom_end_busy", longint'(busy), 0);

        // Partial frame in ARM, mixed signs, then sync loss on bin 1
        pulse_start();
        drive(1'b1, 1'b0, 1'b0, 3'b111);
        drive(1'b1, 1'b0, 1'b0, 3'b111);
        drive(1'b1, 1'b0, 1'b1, 3'b111);
        fr = '{3'b000, 3'b100, 3'b111, 3'b001};
        play_frame(1'b1, 1'b0);
        bubble();
        @(negedge clk);
        chk("mixed_sum_lit", longint'(sum_out), -4);
        chk("mixed_mag_lit", longint'(mag_out), 12);
        chk("mixed_bin", longint'(bin), 1);
        drive(1'b1, 1'b0, 1'b0, 3'b011);
        bubble();
        @(negedge clk);
        chk("sync_error_set", longint'(sync_error), 1);
        chk("sync_bin", longint'(bin), 1);
        chk("sync_mode", longint'(bank.mode), 1);
        drive(1'b1, 1'b0, 1'b1, 3'b001);
        pulse_start();
        @(negedge clk);
        chk("start_in_arm_sync", longint'(sync_error), 1);
        chk("start_in_arm_mode", longint'(bank.mode), 1);
        fr = '{3'b111, 3'b111, 3'b011, 3'b010};
        play_frame(1'b1, 1'b1);
        repeat (3) bubble();
        @(negedge clk);
        chk("resync_sum_lit", longint'(sum_out), -2);
        chk("resync_mag_lit", longint'(mag_out), 26);
        chk("resync_busy", longint'(busy), 0);
        chk("sync_error_sticky", longint'(sync_error), 1);

        // One-sample frame, then abort mid-frame on bin 1
        pulse_start();
        @(negedge clk);
        chk("start_clears_sync", longint'(sync_error), 0);
        bubble();
        fr = '{3'b101};
        play_frame(1'b1, 1'b0);
        bubble();
        @(negedge clk);
        chk("one_sample_sum_lit", longint'(sum_out), -3);
        drive(1'b1, 1'b1, 1'b0, 3'b001);
        drive(1'b1, 1'b0, 1'b0, 3'b011);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bank.sample_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_mode", longint'(bank.mode), 0);
        chk("abort_bin_held", longint'(bin), 1);
        chk("abort_sum_held", longint'(sum_out), -3);
        drive(1'b1, 1'b0, 1'b1, 3'b011);
        repeat (3) bubble();

        // Reset held two cycles in the middle of a frame
        pulse_start();
        bubble();
        fr = '{3'b011};
        play_frame(1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b011);
        drive(1'b1, 1'b0, 1'b0, 3'b011);
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        bank.sample_valid = 1'b0;
        @(negedge clk);
        check_reset_state("mid_rst");
        chk("mid_rst_rv", longint'(result_valid), 0);
        repeat (3) bubble();
        @(negedge clk);
        chk("pending_results", longint'(exp_q.size()), 0);
        chk("pending_done", longint'(done_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_playback_ctrl.md
Name: acq_playback_ctrl

Overview:
- Sequences the sample memory bank that sits directly upstream: drives its mode, waits for a full capture, then consumes NUM_BINS playback frames.
- For each frame it decodes the 3-bit sign/magnitude samples and accumulates a signed sum and a magnitude sum.
- Each frame's result is reported to the acquisition search logic with a one-cycle valid, and the current bin index is exposed so downstream Doppler/code stepping can follow it.

Parameters:
- SAMPLE_WIDTH, 3, sample bits: [2]=sign (1=negative), [1:0]=magnitude code.
- FRAME_LEN, 50400, samples per playback frame; must equal the bank's acquisition length.
- NUM_BINS, 16, frames played back per acquisition run.
- BIN_WIDTH, 6, width of bin index; 2^BIN_WIDTH >= NUM_BINS.
- SUM_WIDTH, 20, signed-sum width (holds ±7*FRAME_LEN).
- MAG_WIDTH, 19, unsigned magnitude-sum width (holds 7*FRAME_LEN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  one-cycle request to end a run; returns to IDLE.
- ready  in  1  bank ready (capture full in writing mode).
- sample_valid  in  1  bank playback sample valid.
- frame_start  in  1  bank first sample of frame.
- frame_end  in  1  bank last sample of frame.
- data_in  in  SAMPLE_WIDTH  bank data_out.
- mode  out  1  to bank; 0 = MODE_WRITING, 1 = MODE_PLAYBACK.
- bin  out  BIN_WIDTH  index of the frame currently accumulating.
- result_valid  out  1  one-cycle strobe; sums below are valid.
- sum_out  out  SUM_WIDTH  signed frame sum.
- mag_out  out  MAG_WIDTH  frame magnitude sum.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle strobe after the last bin's result.
- sync_error  out  1  sticky; cleared by start or reset.

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; all outputs and accumulators are 0, so mode=WRITING. Reset mid-run has the same effect; the bank sees mode fall to WRITING.
- Sample decode: value = 2*mag+1, giving ±1, ±3, ±5, ±7. Negative when sign=1. Sign-extended to SUM_WIDTH. Magnitude contribution is 2*mag+1.
- States:
  - IDLE: mode=0. start -> FILL and clears sync_error.
  - FILL: mode=0. ready=1 -> ARM with mode=1 from the next cycle. ready is sampled only in FILL.
  - ARM: mode=1. Ignores the bank's partial frame. On sample_valid && frame_start -> ACCUM, initialising accumulators with that sample (not zero+sample in a later cycle). bin=0.
  - ACCUM: mode=1. Each sample_valid cycle adds the sample to both sums.
    - On sample_valid && frame_end: final sums (including this sample) go to sum_out/mag_out, result_valid=1 on the next cycle, accumulators clear.
    - If bin==NUM_BINS-1 -> DONE; otherwise bin increments on that same edge and the state stays ACCUM.
    - The next valid sample must carry frame_start. If it does not, set sync_error, discard it, clear accumulators and go to ARM (same bin, re-armed).
  - DONE: one cycle; done=1, mode=0 -> IDLE.
- Latency: result_valid is exactly 1 clk after the frame_end sample. sum_out/mag_out hold until the next result_valid.
- frame_start and frame_end together: treat as a 1-sample frame (FRAME_LEN=1 configuration).
- abort: highest priority after reset in any non-IDLE state -> IDLE next cycle, mode=0. No result_valid or done for the aborted frame. bin and sums are held.
- start while busy: ignored.
- sample_valid=0 in ACCUM: no accumulation, no state change. frame_start/frame_end are ignored when sample_valid=0.
- Arithmetic wraps modulo width. Overflow cannot occur with the defaults.

Test Plan:
- Reset: reset_n=0 for 2 cycles mid-ACCUM -> mode=0, busy=0, bin=0, result_valid=0, sums=0 on the following cycle.
- Nominal run against a real bank instance, FRAME_LEN=50400, NUM_BINS=2, constant sample 3'b011 -> two result_valid pulses 50400 cycles apart, each sum_out=352800, mag_out=352800. bin reads 0 then 1. done one cycle after the second result_valid. mode back to 0.
- Mixed signs, FRAME_LEN=4, sample model with frame samples 3'b000, 3'b100, 3'b111, 3'b001 -> sum_out = 1-1-7+3 = -4, mag_out=12.
- Partial frame: enter ARM three samples before frame_start -> those samples are excluded; first result equals the sum of exactly FRAME_LEN samples.
- Sync loss: after frame_end, deliver a valid sample without frame_start -> sync_error=1, state ARM, bin unchanged. Next proper frame yields a correct result for the same bin.
- Abort and start-while-busy: abort mid-ACCUM -> IDLE next cycle, no result_valid, no done. start pulsed during FILL -> no effect.
